// File: rtl/bram_loader_pkg.sv
// bram_loader_pkg: shared state encoding, write-enable constant and beat-width helper
package bram_loader_pkg;
  typedef enum logic [1:0] {IDLE, LOAD_W, LOAD_I, DONE} state_t;
  localparam logic [7:0] WEA_ALL = 8'hFF;
  function automatic int BEAT_W(input int width, input int chunk_size);
    return width * chunk_size;
  endfunction
endpackage

// File: rtl/bram_loader_beat_packer.sv
// beat_packer: gathers NUM_CORES beats into one wide word, lane 0 in the LSBs
module beat_packer #(
  parameter int BEAT = 64,
  parameter int NUM_CORES = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      clr_i,
  input  logic                      beat_valid_i,
  input  logic [BEAT-1:0]           beat_i,
  output logic                      word_valid_o,
  output logic [BEAT*NUM_CORES-1:0] word_o
);
  localparam int LW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
  logic [LW-1:0] lane_q, lane_d;
  logic [BEAT*NUM_CORES-1:0] pack_q;
  // merge the incoming beat into its lane so a completing word is ready in the same cycle
  always_comb begin
    word_o = pack_q;
    for (int k = 0; k < NUM_CORES; k++)
      word_o[k*BEAT +: BEAT] = (beat_valid_i && lane_q == LW'(k)) ? beat_i : pack_q[k*BEAT +: BEAT];
    word_valid_o = beat_valid_i && lane_q == LW'(NUM_CORES - 1);
    lane_d = !beat_valid_i ? lane_q : word_valid_o ? '0 : lane_q + 1'b1;
  end
  // lane pointer and partial word; clear drops any half-filled pack
  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      lane_q <= '0;
      pack_q <= '0;
    end else begin
      lane_q <= lane_d;
      pack_q <= word_o;
    end
  end
endmodule

// File: rtl/bram_loader.sv
// bram_loader: stream-to-BRAM loader filling weight then packed input memories; BRAM_LOADER_LAST_CHECK_EN enables s_last framing check
module bram_loader import bram_loader_pkg::*; #(
  parameter int WIDTH = 16,
  parameter int CHUNK_SIZE = 4,
  parameter int NUM_CORES = 2,
  parameter int W_DEPTH = 6,
  parameter int I_DEPTH = 6,
  parameter int W_ADDR_WIDTH = 12,
  parameter int I_ADDR_WIDTH = 14,
  localparam int BW = BEAT_W(WIDTH, CHUNK_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic                    err,
  input  logic [BW-1:0]           s_data,
  input  logic                    s_valid,
  input  logic                    s_last,
  output logic                    s_ready,
  output logic                    wb_ena,
  output logic [7:0]              wb_wea,
  output logic [W_ADDR_WIDTH-1:0] wb_addra,
  output logic [BW-1:0]           wb_dina,
  output logic                    in_ena,
  output logic [7:0]              in_wea,
  output logic [I_ADDR_WIDTH-1:0] in_addra,
  output logic [BW*NUM_CORES-1:0] in_dina
);
  localparam logic [W_ADDR_WIDTH-1:0] W_LAST = W_ADDR_WIDTH'(W_DEPTH - 1);
  localparam logic [I_ADDR_WIDTH-1:0] I_LAST = I_ADDR_WIDTH'(I_DEPTH - 1);
  state_t state_q;
  logic [W_ADDR_WIDTH-1:0] w_cnt_q;
  logic [I_ADDR_WIDTH-1:0] i_cnt_q;
  logic word_valid;
  logic [BW*NUM_CORES-1:0] word;
  assign s_ready = state_q == LOAD_W || state_q == LOAD_I;
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  beat_packer #(.BEAT(BW), .NUM_CORES(NUM_CORES)) u_packer (
    .clk(clk),
    .rst(rst),
    .clr_i(state_q == IDLE && start),
    .beat_valid_i(state_q == LOAD_I && s_valid),
    .beat_i(s_data),
    .word_valid_o(word_valid),
    .word_o(word)
  );
  // load sequencer: weight beats one per word, then packed input words, then a one-cycle DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      w_cnt_q <= '0;
      i_cnt_q <= '0;
      wb_ena <= 1'b0;
      wb_wea <= '0;
      wb_addra <= '0;
      wb_dina <= '0;
      in_ena <= 1'b0;
      in_wea <= '0;
      in_addra <= '0;
      in_dina <= '0;
    end else begin
      wb_ena <= 1'b0;
      wb_wea <= '0;
      in_ena <= 1'b0;
      in_wea <= '0;
      case (state_q)
        IDLE: if (start) begin
          state_q <= LOAD_W;
          w_cnt_q <= '0;
          i_cnt_q <= '0;
        end
        LOAD_W: if (s_valid) begin
          wb_ena <= 1'b1;
          wb_wea <= WEA_ALL;
          wb_addra <= w_cnt_q;
          wb_dina <= s_data;
          w_cnt_q <= w_cnt_q == W_LAST ? w_cnt_q : w_cnt_q + 1'b1;
          state_q <= w_cnt_q == W_LAST ? LOAD_I : LOAD_W;
        end
        LOAD_I: if (word_valid) begin
          in_ena <= 1'b1;
          in_wea <= WEA_ALL;
          in_addra <= i_cnt_q;
          in_dina <= word;
          i_cnt_q <= i_cnt_q == I_LAST ? i_cnt_q : i_cnt_q + 1'b1;
          state_q <= i_cnt_q == I_LAST ? DONE : LOAD_I;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`ifdef BRAM_LOADER_LAST_CHECK_EN
  logic err_q;
  logic final_acc;
  assign final_acc = word_valid && i_cnt_q == I_LAST;
  assign err = err_q;
  // sticky framing error: s_last must arrive on exactly the final accepted beat
  always_ff @(posedge clk)
    err_q <= rst || (state_q == IDLE && start) ? 1'b0 : err_q | (s_valid && s_ready && s_last != final_acc);
`else
  logic unused_last;
  assign unused_last = s_last;
  assign err = 1'b0;
`endif
endmodule

// File: tb/tb_bram_loader.sv
// tb_bram_loader: randomized self-checking bench comparing BRAM writes against a packing model
module tb_bram_loader;
  localparam int WD = 3, ID = 2, NC = 2, BW = 64, NB = WD + ID * NC;
`ifdef BRAM_LOADER_LAST_CHECK_EN
  localparam bit LC = 1'b1;
`else
  localparam bit LC = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst, start, s_valid, s_last;
  logic [BW-1:0] s_data;
  logic busy, done, err, s_ready, wb_ena, in_ena;
  logic [7:0] wb_wea, in_wea;
  logic [11:0] wb_addra;
  logic [13:0] in_addra;
  logic [BW-1:0] wb_dina;
  logic [BW*NC-1:0] in_dina;
  typedef struct {logic [11:0] a; logic [BW-1:0] d; logic [7:0] we;} wrec_t;
  typedef struct {logic [13:0] a; logic [BW*NC-1:0] d; logic [7:0] we;} irec_t;
  wrec_t wlog[$];
  irec_t ilog[$];
  int tests = 0, fails = 0;
  int done_cnt, acc_n, err_first;
  logic done_with_in, err_at_done;
  logic [BW-1:0] beats [NB];

  bram_loader #(.WIDTH(16), .CHUNK_SIZE(4), .NUM_CORES(NC), .W_DEPTH(WD), .I_DEPTH(ID),
                .W_ADDR_WIDTH(12), .I_ADDR_WIDTH(14)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .err(err),
    .s_data(s_data), .s_valid(s_valid), .s_last(s_last), .s_ready(s_ready),
    .wb_ena(wb_ena), .wb_wea(wb_wea), .wb_addra(wb_addra), .wb_dina(wb_dina),
    .in_ena(in_ena), .in_wea(in_wea), .in_addra(in_addra), .in_dina(in_dina)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (wb_ena) wlog.push_back(wrec_t'{wb_addra, wb_dina, wb_wea});
    if (in_ena) ilog.push_back(irec_t'{in_addra, in_dina, in_wea});
    if (done) begin
      done_cnt++;
      done_with_in = in_ena;
      err_at_done = err;
    end
    if (err === 1'b1 && err_first < 0) err_first = acc_n;
    if (s_valid && s_ready) acc_n++;
  end

  function automatic logic [BW*NC-1:0] exp_in(input int j);
    logic [BW*NC-1:0] w = '0;
    for (int c = 0; c < NC; c++) w[c*BW +: BW] = beats[WD + j * NC + c];
    return w;
  endfunction

  task automatic clear_mon();
    wlog.delete();
    ilog.delete();
    done_cnt = 0;
    acc_n = 0;
    err_first = -1;
    done_with_in = 1'b0;
    err_at_done = 1'b0;
  endtask

  task automatic gen_beats(input bit rnd);
    for (int i = 0; i < NB; i++) beats[i] = rnd ? {$urandom, $urandom} : BW'(i + 1);
  endtask

  task automatic do_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic drive(input bit gap, input bit poke, input int last_at, input int n);
    int idx = 0;
    bit rdy;
    for (int cyc = 0; idx < n && cyc < 100; cyc++) begin
      s_valid = !gap || cyc % 2 == 0;
      s_data = beats[idx];
      s_last = idx == last_at;
      start = poke && (cyc == 1 || cyc == 4);
      @(negedge clk);
      rdy = s_ready;
      @(posedge clk);
      #1;
      if (rdy && s_valid) idx++;
    end
    s_valid = 1'b0;
    s_last = 1'b0;
    start = 1'b0;
    tests++;
    if (idx != n) begin
      fails++;
      $display("FAIL drive_accepts got=%0d exp=%0d", idx, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    tests++;
    if ({busy, done, err, s_ready, wb_ena, in_ena} !== 6'b0) begin
      fails++; $display("FAIL reset_ctrl got=%b exp=0", {busy, done, err, s_ready, wb_ena, in_ena});
    end
    tests++;
    if ({wb_wea, in_wea} !== 16'h0) begin
      fails++; $display("FAIL reset_wea got=%h exp=0", {wb_wea, in_wea});
    end
    tests++;
    if ({wb_addra, in_addra, wb_dina, in_dina} !== '0) begin
      fails++; $display("FAIL reset_addr_data got=%h exp=0", {wb_addra, in_addra, wb_dina, in_dina});
    end
    clear_mon();
    @(posedge clk);
    #1 s_valid = 1'b1; s_data = {$urandom, $urandom}; s_last = 1'b1;
    repeat (4) @(posedge clk);
    #1 s_valid = 1'b0; s_last = 1'b0;
    tests++;
    if (acc_n != 0 || wlog.size() + ilog.size() != 0 || s_ready !== 1'b0) begin
      fails++; $display("FAIL idle_beats accepts=%0d writes=%0d s_ready=%b exp=0/0/0", acc_n, wlog.size() + ilog.size(), s_ready);
    end
  endtask

  task automatic test_stream(input string name, input bit rnd, input bit gap, input bit poke);
    gen_beats(rnd);
    clear_mon();
    do_start();
    tests++;
    if (busy !== 1'b1 || s_ready !== 1'b1) begin
      fails++; $display("FAIL %s_start busy=%b s_ready=%b exp=1/1", name, busy, s_ready);
    end
    drive(gap, poke, NB - 1, NB);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (wlog.size() != WD || ilog.size() != ID) begin
      fails++; $display("FAIL %s_write_count got=%0d/%0d exp=%0d/%0d", name, wlog.size(), ilog.size(), WD, ID);
    end
    for (int k = 0; k < WD && k < wlog.size(); k++) begin
      tests++;
      if (wlog[k].a !== 12'(k) || wlog[k].d !== beats[k] || wlog[k].we !== 8'hFF) begin
        fails++; $display("FAIL %s_w%0d got=%0d:%h:%h exp=%0d:%h:ff", name, k, wlog[k].a, wlog[k].d, wlog[k].we, k, beats[k]);
      end
    end
    for (int j = 0; j < ID && j < ilog.size(); j++) begin
      tests++;
      if (ilog[j].a !== 14'(j) || ilog[j].d !== exp_in(j) || ilog[j].we !== 8'hFF) begin
        fails++; $display("FAIL %s_i%0d got=%0d:%h:%h exp=%0d:%h:ff", name, j, ilog[j].a, ilog[j].d, ilog[j].we, j, exp_in(j));
      end
    end
    tests++;
    if (done_cnt != 1 || done_with_in !== 1'b1) begin
      fails++; $display("FAIL %s_done count=%0d with_in=%b exp=1/1", name, done_cnt, done_with_in);
    end
    tests++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      fails++; $display("FAIL %s_end busy=%b err=%b exp=0/0", name, busy, err);
    end
  endtask

  task automatic test_rst_midload();
    gen_beats(1'b1);
    clear_mon();
    do_start();
    drive(1'b0, 1'b0, -1, WD + 1);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (ilog.size() != 0 || busy !== 1'b0 || s_ready !== 1'b0) begin
      fails++; $display("FAIL rst_mid in_writes=%0d busy=%b s_ready=%b exp=0/0/0", ilog.size(), busy, s_ready);
    end
    tests++;
    if ({wb_ena, wb_addra, wb_dina, in_addra, in_dina} !== '0) begin
      fails++; $display("FAIL rst_mid_ports got=%h exp=0", {wb_ena, wb_addra, wb_dina, in_addra, in_dina});
    end
    test_stream("after_rst", 1'b1, 1'b0, 1'b0);
  endtask

  task automatic test_last_check();
    gen_beats(1'b1);
    clear_mon();
    do_start();
    drive(1'b0, 1'b0, WD, NB);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (err_first != (LC ? WD + 1 : -1)) begin
      fails++; $display("FAIL early_last_rise got=%0d exp=%0d", err_first, LC ? WD + 1 : -1);
    end
    tests++;
    if (err_at_done !== LC || err !== LC || done_cnt != 1) begin
      fails++; $display("FAIL early_last_sticky at_done=%b now=%b done=%0d exp=%b/%b/1", err_at_done, err, done_cnt, LC, LC);
    end
    clear_mon();
    do_start();
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL err_clear_on_start got=%b exp=0", err);
    end
    drive(1'b0, 1'b0, -1, NB);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (err !== LC) begin
      fails++; $display("FAIL missing_last got=%b exp=%b", err, LC);
    end
    clear_mon();
    do_start();
    drive(1'b0, 1'b0, NB - 1, NB);
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (err !== 1'b0 || err_first != -1) begin
      fails++; $display("FAIL clean_last err=%b first=%0d exp=0/-1", err, err_first);
    end
  endtask

  initial begin
    test_reset();
    test_stream("stream", 1'b0, 1'b0, 1'b0);
    test_stream("gapped", 1'b1, 1'b1, 1'b0);
    test_stream("start_ignored", 1'b1, 1'b0, 1'b1);
    test_rst_midload();
    test_last_check();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end
endmodule

// File: doc/bram_loader.md
# bram_loader

Stream-to-BRAM loader that fills the weight and input `xpm_memory_tdpram` instances through their port A ahead of a matrix-multiply run. It accepts a valid/ready stream of `WIDTH*CHUNK_SIZE`-bit beats. The first `W_DEPTH` beats go one-per-word into the weight BRAM. The next `I_DEPTH*NUM_CORES` beats are packed `NUM_CORES` at a time into wide input-BRAM words. Port B of both memories stays with the compute-side reader; this block is the producer end of that interface.

## Interface
Parameters:
- `WIDTH`, 16, element width in bits
- `CHUNK_SIZE`, 4, elements per stream beat (beat = `WIDTH*CHUNK_SIZE` bits)
- `NUM_CORES`, 2, beats packed per input-BRAM word
- `W_DEPTH`, 6, weight words per load (≥1, ≤ 2**`W_ADDR_WIDTH`)
- `I_DEPTH`, 6, input words per load (≥1, ≤ 2**`I_ADDR_WIDTH`)
- `W_ADDR_WIDTH`, 12, weight port-A address width
- `I_ADDR_WIDTH`, 14, input port-A address width

Ports:
- `clk`  in  1  single clock for everything
- `rst`  in  1  reset; synchronous, active-high
- `start`  in  1  begin a load; sampled only in IDLE
- `busy`  out  1  high whenever state ≠ IDLE
- `done`  out  1  one-cycle pulse at end of load
- `err`  out  1  sticky framing error (see Configuration)
- `s_data`  in  `WIDTH*CHUNK_SIZE`  stream beat
- `s_valid`  in  1  beat valid
- `s_last`  in  1  marks final beat of the load
- `s_ready`  out  1  loader accepts a beat
- `wb_ena`  out  1  weight port-A enable
- `wb_wea`  out  8  weight byte write enables
- `wb_addra`  out  `W_ADDR_WIDTH`  weight write address
- `wb_dina`  out  `WIDTH*CHUNK_SIZE`  weight write data
- `in_ena`  out  1  input port-A enable
- `in_wea`  out  8  input byte write enables
- `in_addra`  out  `I_ADDR_WIDTH`  input write address
- `in_dina`  out  `WIDTH*CHUNK_SIZE*NUM_CORES`  input write data

## Operation
- Handshake: beat accepted on a rising edge with `s_valid && s_ready`. `s_ready = (state==LOAD_W || state==LOAD_I)`, combinational from state only. Never depends on `s_valid`.
- FSM states and transitions:
  - IDLE: `start` → LOAD_W. Clear `w_cnt`, `i_cnt`, `lane`, and `err`.
  - LOAD_W: each accept writes the beat to weight address `w_cnt`, then `w_cnt++`. The accept with `w_cnt==W_DEPTH-1` → LOAD_I.
  - LOAD_I: each accept stores the beat in pack lane `lane`, bits `[lane*WIDTH*CHUNK_SIZE +: WIDTH*CHUNK_SIZE]`; lane 0 is the LSBs.
    - When `lane==NUM_CORES-1`, the full word is written to input address `i_cnt`, `i_cnt++`, and `lane` returns to 0.
    - The accept completing word `I_DEPTH-1` → DONE.
  - DONE: `done`=1 for this cycle only, → IDLE.
- Writes:
  - All write-port outputs are registered and valid in the cycle following the accepting edge.
  - `*_ena` is high for exactly one cycle per write, with `*_wea=8'hFF`.
  - When not writing: `*_ena=0`, `*_wea=0`; address and data hold their last values.
- `start` outside IDLE is ignored. Beats offered in IDLE/DONE are not accepted.
- Counters never wrap: the FSM leaves the load state on the final count.

## Timing
- Reset values:
  - state IDLE; all counters and `lane` 0.
  - `busy`, `done`, `err`, `s_ready`, `wb_ena`, `in_ena` = 0; `wb_wea`, `in_wea` = 0.
  - Addresses and data = 0.
- `start` at edge E → `busy`, `s_ready` high from E.
- Accept → BRAM write strobe: 1 cycle. Sustained throughput is 1 beat/cycle with no bubbles.
- Final accept at edge F: state=DONE and last write strobe both during cycle F..F+1, with `done`=1. `busy`=0 from F+1.
- Minimum load length: `W_DEPTH + I_DEPTH*NUM_CORES` cycles + 1 (DONE).
- `rst` mid-load: next cycle equals reset state. Partial pack is discarded, no write is issued, and the next load restarts at address 0.
- `rst` and `start` in the same cycle: `rst` wins.

## Configuration
- `BRAM_LOADER_LAST_CHECK_EN` defined:
  - `err` is set if `s_last` is accepted on any beat but the final one, or the final beat is accepted without `s_last`.
  - `err` is sticky until the next `start` or `rst`. The load continues regardless.
- Undefined: `s_last` is ignored and `err` is tied 0.

## Structure
- Shared package `bram_loader_pkg`:
  - state enum (IDLE, LOAD_W, LOAD_I, DONE)
  - constant `WEA_ALL = 8'hFF`
  - beat-width function `BEAT_W(WIDTH, CHUNK_SIZE)`
- One sub-module, `beat_packer`, holds the lane counter and the wide shift/pack register. It emits `word_valid` and `word` when `NUM_CORES` beats are collected, and has a synchronous clear.

## Test plan
- Reset: assert `rst` 2 cycles → every output 0, `s_ready=0`. Beats offered in IDLE → not accepted, no writes.
- Streaming load, `W_DEPTH=3`, `I_DEPTH=2`, `NUM_CORES=2`, `CHUNK_SIZE=4`, `WIDTH=16`, `s_valid` held high, beats 1..7:
  - weight writes at addresses 0/1/2 with data 1/2/3, each with `wb_wea=8'hFF`
  - input address 0 = {5,4}, input address 1 = {7,6}
  - `done` pulses exactly once, in the same cycle as the last `in_ena`
- Gapped `s_valid` (high every other cycle), same data → identical memory contents, no extra `*_ena` pulses, `done` once.
- `start` pulsed during LOAD_W and LOAD_I → ignored; counters and addresses unaffected.
- `rst` after the first LOAD_I beat → no `in_ena` issued, back in IDLE. A new full load writes input address 0 first with the fresh beats.
- With `BRAM_LOADER_LAST_CHECK_EN`:
  - `s_last` on beat 4 → `err=1` from the next cycle, stays 1 through `done`, cleared by the next `start`.
  - Final beat without `s_last` → `err=1`.
